hint_2_polyphase: RTL and testbench
===================================

HINT_2_POLYPHASE -- requirements
Module: hint_2_polyphase

Interface
REQ-001 SHALL have parameter word_size_in, default 8, meaning bit-size of signed two's-complement input X.
REQ-002 SHALL have parameter word_size_out, default 18, meaning bit-size of signed output Y (word_size_in + ceil(log2(sum|h|)) + 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous clear of the delay line and FSM.
REQ-006 SHALL have port X  input  word_size_in  signed input sample at the low rate.
REQ-007 SHALL have port X_valid  input  1  X holds a valid sample.
REQ-008 SHALL have port X_ready  output  1  block accepts X this cycle.
REQ-009 SHALL have port Y  output  word_size_out  signed interpolated sample at twice the rate, registered.
REQ-010 SHALL have port Y_valid  output  1  Y holds a valid sample.
REQ-011 SHALL have port Y_ready  input  1  downstream accepts Y this cycle.
REQ-012 SHALL have port Y_phase  output  1  0 = even polyphase output, 1 = odd.

Function
REQ-013 SHALL implement x2 half-band interpolation with fixed integer taps h = [3,0,-25,0,150,256,150,0,-25,0,3] (DC gain 512 at the high rate, 256 per phase).
REQ-014 SHALL hold a 6-entry signed delay line d0..d5 (d0 newest); on accept: d0<=X, dk<=d(k-1).
REQ-015 SHALL produce even sample E = 3*d0 - 25*d1 + 150*d2 + 150*d3 - 25*d4 + 3*d5 and odd sample O = 256*d2, both from the post-shift delay line, E emitted before O.
REQ-016 SHALL implement the coefficient products with shift-add only (no multipliers), full precision, no rounding or saturation; |Y| <= 45568 and never overflows 18 bits.
REQ-017 SHALL use FSM states S_IN, S_CALC, S_EVEN, S_ODD.
REQ-018 S_IN: X_ready=1, Y_valid=0; on X_valid=1 accept X, shift the delay line, go to S_CALC; otherwise stay.
REQ-019 S_CALC: X_ready=0; register Y<=E, Y_phase<=0; go to S_EVEN.
REQ-020 S_EVEN: Y_valid=1; on Y_ready=1 register Y<=O, Y_phase<=1, go to S_ODD; otherwise hold Y, Y_phase, state.
REQ-021 S_ODD: Y_valid=1; on Y_ready=1 go to S_IN with Y_valid=0 next cycle; otherwise hold.
REQ-022 SHALL keep X_ready=0 in every state except S_IN; X and X_valid are ignored there.
REQ-023 SHALL hold Y, Y_phase and Y_valid stable while Y_valid=1 and Y_ready=0 (no drop, no change).
REQ-024 With Y_ready held 1, latency from accept to even output valid SHALL be 2 cycles; max throughput one input per 4 cycles.
REQ-025 clr=1 SHALL, on the next edge, zero d0..d5 and Y, clear Y_valid and Y_phase, and force S_IN; clr has priority over X_valid and Y_ready in the same cycle.

Reset
REQ-026 On reset=0, asynchronously: state S_IN, d0..d5=0, Y=0, Y_valid=0, Y_phase=0; X_ready=1 after release.
REQ-027 Reset asserted mid-transaction SHALL abandon any pending even/odd sample; no output appears after release until a new input is accepted.

Verification
REQ-028 Impulse: X=1 then five X=0, Y_ready=1 -> Y pairs (E,O): (3,0),(-25,0),(150,256),(150,0),(-25,0),(3,0), Y_phase alternating 0,1.
REQ-029 DC: X=100 repeated -> from 6th input on E=25600, O=25600; X=-128 repeated -> E=O=-32768.
REQ-030 Backpressure: Y_ready=0 for 5 cycles in S_EVEN with X_valid=1 -> Y, Y_phase=0, Y_valid=1 stable, X_ready=0, no input accepted; release -> O delivered next.
REQ-031 Peak: inputs 127,-128,127,127,-128,127 (oldest first) -> E=45262, no wrap.
REQ-032 Reset in S_ODD, then X=1 -> Y_valid=0 through reset, first post-reset pair (3,0).
REQ-033 clr and X_valid=1 in the same S_IN cycle -> input not accepted, delay line zero, next X=1 yields (3,0).

Source files
------------

// File: rtl/hint_2_polyphase_if.sv
// hint_2_polyphase_if
// Groups the clear, input-stream and output-stream signals of the x2
// half-band polyphase interpolator.
//   clr              : synchronous clear request
//   X / X_valid      : low-rate signed input sample and its valid flag
//   X_ready          : interpolator accepts X this cycle
//   Y / Y_valid      : high-rate signed output sample and its valid flag
//   Y_ready          : downstream accepts Y this cycle
//   Y_phase          : 0 = even polyphase output, 1 = odd
// Modports: master = the surrounding system, slave = the interpolator.
interface hint_2_polyphase_if #(
    parameter int word_size_in  = 8,
    parameter int word_size_out = 18
);
    logic                            clr;
    logic signed [word_size_in-1:0]  X;
    logic                            X_valid;
    logic                            X_ready;
    logic signed [word_size_out-1:0] Y;
    logic                            Y_valid;
    logic                            Y_ready;
    logic                            Y_phase;

    modport master (
        output clr, X, X_valid, Y_ready,
        input  X_ready, Y, Y_valid, Y_phase
    );

    modport slave (
        input  clr, X, X_valid, Y_ready,
        output X_ready, Y, Y_valid, Y_phase
    );
endinterface

// File: rtl/hint_2_polyphase.sv
// hint_2_polyphase
// x2 half-band interpolator, taps h = [3,0,-25,0,150,256,150,0,-25,0,3].
// Each accepted input produces two outputs: the even phase
// E = 3*d0 - 25*d1 + 150*d2 + 150*d3 - 25*d4 + 3*d5, then the odd phase
// O = 256*d2, both taken from the delay line after the new sample is shifted in.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of hint_2_polyphase_if (clr, X stream in, Y stream out)
module hint_2_polyphase #(
    parameter int word_size_in  = 8,
    parameter int word_size_out = 18
) (
    input  logic                clk,
    input  logic                reset,
    hint_2_polyphase_if.slave   bus
);
    localparam int TAPS = 6;
    localparam int EXT  = word_size_out - word_size_in;

    typedef enum logic [1:0] {S_IN, S_CALC, S_EVEN, S_ODD} state_t;

    state_t                          state_reg, state_next;
    logic signed [word_size_in-1:0]  d_reg  [TAPS];
    logic signed [word_size_in-1:0]  d_next [TAPS];
    logic signed [word_size_out-1:0] y_reg, y_next;
    logic                            y_phase_reg, y_phase_next;

    // Constant-coefficient products built from shifts and adds only.
    function automatic logic signed [word_size_out-1:0] mul3(
        input logic signed [word_size_out-1:0] v);
        return (v <<< 1) + v;
    endfunction

    function automatic logic signed [word_size_out-1:0] mul25(
        input logic signed [word_size_out-1:0] v);
        return (v <<< 4) + (v <<< 3) + v;
    endfunction

    function automatic logic signed [word_size_out-1:0] mul150(
        input logic signed [word_size_out-1:0] v);
        return (v <<< 7) + (v <<< 4) + (v <<< 2) + (v <<< 1);
    endfunction

    // Sign-extended taps and their unsigned-magnitude coefficient products.
    // The signs of the -25 taps are applied in the final sum.
    logic signed [word_size_out-1:0] ext  [TAPS];
    logic signed [word_size_out-1:0] prod [TAPS];

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign ext[gi] = {{EXT{d_reg[gi][word_size_in-1]}}, d_reg[gi]};
            if (gi == 0 || gi == 5) begin : g_c3
                assign prod[gi] = mul3(ext[gi]);
            end else if (gi == 1 || gi == 4) begin : g_c25
                assign prod[gi] = mul25(ext[gi]);
            end else begin : g_c150
                assign prod[gi] = mul150(ext[gi]);
            end
        end
    endgenerate

    logic signed [word_size_out-1:0] even_sum;
    logic signed [word_size_out-1:0] odd_sum;

    assign even_sum = prod[0] - prod[1] + prod[2] + prod[3] - prod[4] + prod[5];
    // Odd phase has a single non-zero tap (256) sitting on d2.
    assign odd_sum  = ext[2] <<< 8;

    // Next-state and datapath decisions.
    always_comb begin
        state_next   = state_reg;
        d_next       = d_reg;
        y_next       = y_reg;
        y_phase_next = y_phase_reg;

        if (bus.clr) begin
            // Clear wins over any handshake arriving in the same cycle.
            state_next   = S_IN;
            for (int k = 0; k < TAPS; k++) begin
                d_next[k] = '0;
            end
            y_next       = '0;
            y_phase_next = 1'b0;
        end else begin
            case (state_reg)
                S_IN: begin
                    if (bus.X_valid) begin
                        d_next[0] = bus.X;
                        for (int k = 1; k < TAPS; k++) begin
                            d_next[k] = d_reg[k-1];
                        end
                        state_next = S_CALC;
                    end
                end
                S_CALC: begin
                    // d_reg already holds the post-shift line here.
                    y_next       = even_sum;
                    y_phase_next = 1'b0;
                    state_next   = S_EVEN;
                end
                S_EVEN: begin
                    if (bus.Y_ready) begin
                        y_next       = odd_sum;
                        y_phase_next = 1'b1;
                        state_next   = S_ODD;
                    end
                end
                S_ODD: begin
                    if (bus.Y_ready) begin
                        state_next = S_IN;
                    end
                end
                default: begin
                    state_next = S_IN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IN;
            for (int k = 0; k < TAPS; k++) begin
                d_reg[k] <= '0;
            end
            y_reg       <= '0;
            y_phase_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            d_reg       <= d_next;
            y_reg       <= y_next;
            y_phase_reg <= y_phase_next;
        end
    end

    assign bus.X_ready = (state_reg == S_IN);
    assign bus.Y_valid = (state_reg == S_EVEN) || (state_reg == S_ODD);
    assign bus.Y       = y_reg;
    assign bus.Y_phase = y_phase_reg;

endmodule

// File: tb/tb_hint_2_polyphase.sv
// tb_hint_2_polyphase
// Directed, table-driven bench for hint_2_polyphase: impulse, DC, peak
// vectors from a struct table plus hand-written backpressure, clear and
// mid-transaction reset sequences. One line per transaction.
module tb_hint_2_polyphase;
    logic clk;
    logic reset;

    hint_2_polyphase_if #(.word_size_in(8), .word_size_out(18)) bus ();

    hint_2_polyphase #(.word_size_in(8), .word_size_out(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        int    x;
        int    e;
        int    o;
        bit    chk;
        string nm;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int y_int();
        return int'(bus.Y);
    endfunction

    // Called at a negedge with Y_ready = 1; returns at a negedge in S_IN.
    task automatic run_vec(input int x, input int e, input int o,
                           input bit do_val, input string nm);
        int n;
        n = 0;
        while (!bus.X_ready && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_xready"}, int'(bus.X_ready), 1);
        bus.X       = 8'(x);
        bus.X_valid = 1'b1;
        @(negedge clk);
        bus.X_valid = 1'b0;
        n = 0;
        while (!bus.Y_valid && n < 20) begin @(negedge clk); n++; end
        // Accept edge, then one calc edge before even output is valid.
        chk({nm, "_latency"}, n, 1);
        chk({nm, "_ph0"}, int'(bus.Y_phase), 0);
        if (do_val) chk({nm, "_even"}, y_int(), e);
        $display("txn %s: x=%0d even Y=%0d", nm, x, y_int());
        @(negedge clk);
        chk({nm, "_oddvalid"}, int'(bus.Y_valid), 1);
        chk({nm, "_ph1"}, int'(bus.Y_phase), 1);
        if (do_val) chk({nm, "_odd"}, y_int(), o);
        $display("txn %s: x=%0d odd  Y=%0d", nm, x, y_int());
        @(negedge clk);
    endtask

    initial begin
        // Impulse response
        vecs[0]  = '{1,    3,      0,     1'b1, "imp0"};
        vecs[1]  = '{0,    -25,    0,     1'b1, "imp1"};
        vecs[2]  = '{0,    150,    256,   1'b1, "imp2"};
        vecs[3]  = '{0,    150,    0,     1'b1, "imp3"};
        vecs[4]  = '{0,    -25,    0,     1'b1, "imp4"};
        vecs[5]  = '{0,    3,      0,     1'b1, "imp5"};
        // DC 100 step (line holds 0,0,0,0,0,1 before the first entry)
        vecs[6]  = '{100,  300,    0,     1'b1, "dc100_0"};
        vecs[7]  = '{100,  -2200,  0,     1'b1, "dc100_1"};
        vecs[8]  = '{100,  12800,  25600, 1'b1, "dc100_2"};
        vecs[9]  = '{100,  27800,  25600, 1'b1, "dc100_3"};
        vecs[10] = '{100,  25300,  25600, 1'b1, "dc100_4"};
        vecs[11] = '{100,  25600,  25600, 1'b1, "dc100_5"};
        // Step from +100 to -128
        vecs[12] = '{-128, 24916,  25600,  1'b1, "dcm128_0"};
        vecs[13] = '{-128, 30616,  25600,  1'b1, "dcm128_1"};
        vecs[14] = '{-128, -3584,  -32768, 1'b1, "dcm128_2"};
        vecs[15] = '{-128, -37784, -32768, 1'b1, "dcm128_3"};
        vecs[16] = '{-128, -32084, -32768, 1'b1, "dcm128_4"};
        vecs[17] = '{-128, -32768, -32768, 1'b1, "dcm128_5"};
        // Peak pattern, only the fully populated line is value-checked
        vecs[18] = '{127,  0,      0,     1'b0, "peak0"};
        vecs[19] = '{-128, 0,      0,     1'b0, "peak1"};
        vecs[20] = '{127,  0,      0,     1'b0, "peak2"};
        vecs[21] = '{127,  0,      0,     1'b0, "peak3"};
        vecs[22] = '{-128, 0,      0,     1'b0, "peak4"};
        vecs[23] = '{127,  45262,  32512, 1'b1, "peak5"};

        reset       = 1'b0;
        bus.clr     = 1'b0;
        bus.X       = '0;
        bus.X_valid = 1'b0;
        bus.Y_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_yvalid", int'(bus.Y_valid), 0);
        chk("rst_y", y_int(), 0);
        chk("rst_phase", int'(bus.Y_phase), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_xready", int'(bus.X_ready), 1);
        chk("rst_idle_yvalid", int'(bus.Y_valid), 0);

        for (int i = 0; i < 24; i++) begin
            run_vec(vecs[i].x, vecs[i].e, vecs[i].o, vecs[i].chk, vecs[i].nm);
        end

        // Clear together with X_valid in S_IN: input dropped, line zeroed.
        bus.clr     = 1'b1;
        bus.X       = 8'sd55;
        bus.X_valid = 1'b1;
        @(negedge clk);
        bus.clr     = 1'b0;
        bus.X_valid = 1'b0;
        chk("clr_xready", int'(bus.X_ready), 1);
        chk("clr_yvalid", int'(bus.Y_valid), 0);
        chk("clr_y", y_int(), 0);
        $display("txn clr: clear with X_valid");
        run_vec(1, 3, 0, 1'b1, "clr_imp");

        // Backpressure in S_EVEN for five cycles, X_valid held high.
        bus.Y_ready = 1'b0;
        bus.X       = 8'sd0;
        bus.X_valid = 1'b1;
        @(negedge clk);
        bus.X       = 8'sd77;
        begin
            int n;
            n = 0;
            while (!bus.Y_valid && n < 20) begin @(negedge clk); n++; end
            chk("bp_reach_even", n, 1);
        end
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_y", y_int(), -25);
            chk("bp_hold_phase", int'(bus.Y_phase), 0);
            chk("bp_hold_valid", int'(bus.Y_valid), 1);
            chk("bp_xready", int'(bus.X_ready), 0);
            $display("txn bp cycle %0d: Y=%0d stalled", c, y_int());
            @(negedge clk);
        end
        bus.X_valid = 1'b0;
        bus.Y_ready = 1'b1;
        @(negedge clk);
        chk("bp_odd_y", y_int(), 0);
        chk("bp_odd_phase", int'(bus.Y_phase), 1);
        $display("txn bp release: odd Y=%0d", y_int());
        @(negedge clk);
        // If 77 had slipped in during the stall this pair would differ.
        run_vec(0, 150, 256, 1'b1, "bp_after");

        // Reset while parked in S_ODD.
        bus.X       = 8'sd9;
        bus.X_valid = 1'b1;
        @(negedge clk);
        bus.X_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.Y_ready = 1'b0;
        chk("rodd_phase", int'(bus.Y_phase), 1);
        chk("rodd_valid", int'(bus.Y_valid), 1);
        reset = 1'b0;
        #1;
        chk("rodd_async_valid", int'(bus.Y_valid), 0);
        chk("rodd_async_y", y_int(), 0);
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b1;
        bus.Y_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rodd_no_output", int'(bus.Y_valid), 0);
        end
        $display("txn reset in S_ODD: pending odd sample abandoned");
        run_vec(1, 3, 0, 1'b1, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
